operand_fetch: RTL

Issue/operand-fetch stage directly upstream of `register_file`. Accepts one decoded instruction per cycle, drives the register file read addresses and captures the returned operands into an output pipeline register. A 32-entry scoreboard tracks destination registers with writes in flight, and RAW/WAW hazards stall the stage. The register file write port (`enable`/`rdAdrs`/`rdData`) is observed as the writeback bus that retires scoreboard entries.

---
 rtl/operand_fetch_if.sv | 45 ++++
 rtl/operand_fetch.sv | 105 ++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: decoded-instruction input, register file read port,
// writeback observation and downstream pipeline register outputs.
// master: upstream/environment side; slave: the operand_fetch stage.
interface operand_fetch_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 8
);
  logic            inValid;
  logic            inReady;
  logic [OPW-1:0]  inOp;
  logic [4:0]      inRs1Adrs;
  logic [4:0]      inRs2Adrs;
  logic [4:0]      inRdAdrs;
  logic            inUsesRs1;
  logic            inUsesRs2;
  logic            inWritesRd;
  logic [4:0]      rs1Adrs;
  logic [4:0]      rs2Adrs;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic            wbEnable;
  logic [4:0]      wbAdrs;
  logic [XLEN-1:0] wbData;
  logic            outValid;
  logic            outReady;
  logic [OPW-1:0]  outOp;
  logic [XLEN-1:0] outRs1Data;
  logic [XLEN-1:0] outRs2Data;
  logic [4:0]      outRdAdrs;
  logic            outWritesRd;

  modport master (
    output inValid, inOp, inRs1Adrs, inRs2Adrs, inRdAdrs, inUsesRs1, inUsesRs2, inWritesRd,
    output rs1Data, rs2Data, wbEnable, wbAdrs, wbData, outReady,
    input  inReady, rs1Adrs, rs2Adrs, outValid, outOp, outRs1Data, outRs2Data, outRdAdrs,
    input  outWritesRd
  );

  modport slave (
    input  inValid, inOp, inRs1Adrs, inRs2Adrs, inRdAdrs, inUsesRs1, inUsesRs2, inWritesRd,
    input  rs1Data, rs2Data, wbEnable, wbAdrs, wbData, outReady,
    output inReady, rs1Adrs, rs2Adrs, outValid, outOp, outRs1Data, outRs2Data, outRdAdrs,
    output outWritesRd
  );
endinterface

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: drives register file read addresses, tracks in-flight
// destination registers in a 32-entry busy scoreboard, stalls on RAW/WAW hazards and
// captures operands into a one-entry output pipeline register.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN forwards the writeback bus into
// the operands so a dependent instruction can issue in the writeback cycle.
module operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 8
) (
  input logic            clock,
  input logic            reset,
  operand_fetch_if.slave bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic [31:0]     busy_q, busy_d;
  logic            can_load, hz1, hz2, hzd, byp1, byp2, in_ready, accept;
  logic [XLEN-1:0] op1, op2;
  logic [OPW-1:0]  out_op_q;
  logic [XLEN-1:0] out_rs1_q, out_rs2_q;
  logic [4:0]      out_rd_q;
  logic            out_wr_q;

  assign bus.rs1Adrs     = bus.inRs1Adrs;
  assign bus.rs2Adrs     = bus.inRs2Adrs;
  assign bus.inReady     = in_ready;
  assign bus.outValid    = (state_q == StFull);
  assign bus.outOp       = out_op_q;
  assign bus.outRs1Data  = out_rs1_q;
  assign bus.outRs2Data  = out_rs2_q;
  assign bus.outRdAdrs   = out_rd_q;
  assign bus.outWritesRd = out_wr_q;

  // Hazard detection, operand selection and issue handshake.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
    byp1 = bus.wbEnable && (bus.wbAdrs == bus.inRs1Adrs) && (bus.inRs1Adrs != 5'd0);
    byp2 = bus.wbEnable && (bus.wbAdrs == bus.inRs2Adrs) && (bus.inRs2Adrs != 5'd0);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    op1 = byp1 ? bus.wbData : bus.rs1Data;
    op2 = byp2 ? bus.wbData : bus.rs2Data;
    hz1 = bus.inUsesRs1 && busy_q[bus.inRs1Adrs] && !byp1;
    hz2 = bus.inUsesRs2 && busy_q[bus.inRs2Adrs] && !byp2;
    // A retiring write to the same rd frees the slot for the new writer.
    hzd = bus.inWritesRd && busy_q[bus.inRdAdrs] &&
          !(bus.wbEnable && (bus.wbAdrs == bus.inRdAdrs));
    can_load = (state_q == StEmpty) || bus.outReady;
    in_ready = can_load && !hz1 && !hz2 && !hzd;
    accept   = bus.inValid && in_ready;
  end

  // Scoreboard update: clear on writeback first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.wbEnable && (bus.wbAdrs != 5'd0)) busy_d[bus.wbAdrs] = 1'b0;
    if (accept && bus.inWritesRd && (bus.inRdAdrs != 5'd0)) busy_d[bus.inRdAdrs] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output register occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (!accept && bus.outReady) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // State and scoreboard registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEmpty;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Output payload register, loaded only on accept so it holds under backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_op_q  <= '0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= 1'b0;
    end else if (accept) begin
      out_op_q  <= bus.inOp;
      out_rs1_q <= op1;
      out_rs2_q <= op2;
      out_rd_q  <= bus.inRdAdrs;
      out_wr_q  <= bus.inWritesRd;
    end
  end

endmodule
